// File: rtl/pwm_capture_if.sv
// PWM capture bus: sampled pwm line in, measurement report out.
// master = capture block, slave = consumer driving the line.
interface pwm_capture_if #(
  parameter int LENGHT = 10,
  parameter int CNT_W  = 12
);
  logic              pwm_in;
  logic              valid;
  logic [CNT_W-1:0]  high_time;
  logic [CNT_W-1:0]  period;
  logic [LENGHT-1:0] number;
  logic              period_ok;
  logic              stuck;
  logic              level;

  modport master (
    input  pwm_in,
    output valid, high_time, period, number,
    output period_ok, stuck, level
  );

  modport slave (
    output pwm_in,
    input  valid, high_time, period, number,
    input  period_ok, stuck, level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period (rise to rise) of pwm_in,
// reports duty in generator encoding and flags a stuck line by timeout.
module pwm_capture #(
  parameter int LENGHT  = 10,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_capture_if.master bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int NMAX = 2**LENGHT - 1;
  localparam int FULL = 2**LENGHT;

  state_t            state;
  logic              sync1;
  logic              pwm_s;
  logic              pwm_d;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [LENGHT-1:0] hi_sat;
  logic              rise;
  logic              tmo;

  assign rise = pwm_s & ~pwm_d;
  // rise has priority over a coincident timeout
  assign tmo  = (per_cnt == CNT_W'(TIMEOUT)) & ~rise;

  always_comb begin
    hi_sat = LENGHT'(hi_cnt);
    if (32'(hi_cnt) > NMAX)
      hi_sat = LENGHT'(NMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sync1         <= 1'b0;
      pwm_s         <= 1'b0;
      pwm_d         <= 1'b0;
      per_cnt       <= '0;
      hi_cnt        <= '0;
      bus.valid     <= 1'b0;
      bus.high_time <= '0;
      bus.period    <= '0;
      bus.number    <= '0;
      bus.period_ok <= 1'b0;
      bus.stuck     <= 1'b0;
      bus.level     <= 1'b0;
    end else begin
      sync1     <= bus.pwm_in;
      pwm_s     <= sync1;
      pwm_d     <= pwm_s;
      bus.valid <= 1'b0;
      unique case (1'b1)
        rise: begin
          per_cnt <= CNT_W'(1);
          hi_cnt  <= CNT_W'(1);
          state   <= RUN;
          if (state == RUN) begin
            bus.valid     <= 1'b1;
            bus.high_time <= hi_cnt;
            bus.period    <= per_cnt;
            bus.number    <= hi_sat;
            bus.period_ok <= (32'(per_cnt) == FULL);
            bus.stuck     <= 1'b0;
            bus.level     <= 1'b0;
          end
        end
        tmo: begin
          per_cnt       <= CNT_W'(1);
          state         <= IDLE;
          bus.valid     <= 1'b1;
          bus.stuck     <= 1'b1;
          bus.level     <= pwm_s;
          bus.period    <= CNT_W'(TIMEOUT);
          bus.high_time <= pwm_s ? CNT_W'(TIMEOUT) : '0;
          bus.number    <= pwm_s ? LENGHT'(NMAX) : '0;
          bus.period_ok <= 1'b0;
        end
        default: begin
          per_cnt <= per_cnt + 1'b1;
          if (pwm_s && state == RUN)
            hi_cnt <= hi_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule
